context_store_init: RTL and testbench
=====================================

Name: context_store_init

Overview:
- Parametrised successor of the JPEG-LS context memory: one store holding the per-context A, B, C, N and Nn fields.
- Has one read port and one write port, with per-field write enables.
- Adds what the earlier block lacked: a self-clearing initialisation sweep (JPEG-LS default context values), same-cycle read/write collision forwarding, a read-valid strobe and out-of-range address detection.
- Sits between the context-index computation and the context-update/Golomb stages; rerun via init_req at every scan start.

Parameters:
- DEPTH, 367, number of contexts (365 regular + 2 run-interruption).
- ADDR_W, 9, context address width; must satisfy 2**ADDR_W >= DEPTH.
- A_W, 16, width of A field.
- B_W, 8, width of B field (two's complement).
- C_W, 8, width of C field (two's complement).
- N_W, 7, width of N field.
- NN_W, 7, width of Nn field.
- A_INIT, 4, initial A value, max(2,(RANGE+32)/64); default is for RANGE=256.
- N_INIT, 1, initial N value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- init_req  in  1  one-cycle pulse: restart initialisation sweep.
- ready  out  1  high when the store accepts reads/writes.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read context number.
- rd_valid  out  1  pulses the cycle read data is valid.
- a_rd  out  A_W  A field read data.
- b_rd  out  B_W  B field read data.
- c_rd  out  C_W  C field read data.
- n_rd  out  N_W  N field read data.
- nn_rd  out  NN_W  Nn field read data.
- wr_en  in  5  per-field write enable, bit order {Nn,N,C,B,A}.
- wr_addr  in  ADDR_W  write context number.
- a_wr  in  A_W  A field write data.
- b_wr  in  B_W  B field write data.
- c_wr  in  C_W  C field write data.
- n_wr  in  N_W  N field write data.
- nn_wr  in  NN_W  Nn field write data.
- oob_err  out  1  sticky: a read or write addressed >= DEPTH.

Behaviour:
- Reset (rst=1 at clk edge):
  - All read outputs, rd_valid and oob_err go to 0; ready goes to 0.
  - FSM enters INIT with sweep counter at 0.
  - Reset mid-sweep restarts the sweep from 0.
- FSM states IDLE_RDY and INIT:
  - INIT writes {A_INIT, 0, 0, N_INIT, 0} to entry cnt, one entry per cycle.
  - At cnt==DEPTH-1 it writes the last entry and moves to IDLE_RDY; ready=1 from the next cycle.
  - Sweep takes exactly DEPTH cycles after reset deassertion.
  - init_req in IDLE_RDY drops ready next cycle and enters INIT at cnt=0. init_req during INIT restarts cnt at 0.
- While ready=0:
  - rd_en and wr_en are ignored; no rd_valid.
  - Outputs hold their last value.
- Read:
  - rd_en=1 with ready=1 at edge t gives data at edge t+1 with rd_valid=1 for one cycle (latency 1).
  - Outputs hold their value when rd_valid=0.
- Write:
  - Each field whose wr_en bit is set is written at the edge; other fields are unchanged.
  - wr_en=0 is a no-op.
- Collision: same-cycle rd_addr==wr_addr with rd_en and any wr_en bit set.
  - Returned data is write-first per field: enabled fields return the new write data; non-enabled fields return the stored value.
  - A read one cycle after a write naturally returns the written data.
- Out-of-range address (>= DEPTH):
  - An out-of-range write is dropped.
  - An out-of-range read returns all-zero fields with rd_valid still pulsed.
  - Either case sets oob_err, which is cleared only by rst or by starting INIT.
  - oob_err is not set while ready=0.
- Arithmetic: no arithmetic on stored data. B and C are stored as raw bits; sign interpretation belongs downstream.
- Storage: behavioural register array, one per field, inferable to RAM/regfile. Read registered; no asynchronous read path to outputs.

Decomposition:
- Shared package/include (with the existing JPEG-LS parameter file) holds:
  - default widths (A_W..NN_W);
  - DEPTH=367;
  - FSM state encoding;
  - wr_en bit indices FLD_A=0, FLD_B=1, FLD_C=2, FLD_N=3, FLD_NN=4.
- One sub-module, ctx_field_ram (parametrised WIDTH/DEPTH; 1R1W; registered read; write-first bypass), instantiated five times.
- Top level holds only the init FSM, counter, muxing and the oob check.

Test Plan:
- Reset then idle:
  - ready=0 for 367 cycles, then 1.
  - Reads of addresses 0, 200 and 366 return A=4, B=0, C=0, N=1, Nn=0.
- Partial write: wr_en=5'b01001, addr 10, A=77, N=5, B=-3 -> read 10 returns A=77, N=5, B=0, C=0, Nn=0.
- Collision at addr 20, same cycle as rd_en:
  - Preload C=9, then write wr_en=5'b00100 with C=-2 (0xFE) together with a read of 20.
  - Next cycle: c_rd=0xFE, A=4 and rd_valid=1.
- Out of range:
  - A write to 400 followed by a read of 400 -> read returns zeros and oob_err=1.
  - Entries 0..366 are unchanged.
- init_req mid-operation:
  - After writing A=100 at addr 5, pulse init_req.
  - ready=0 for 367 cycles; rd_en during the sweep gives no rd_valid.
  - Afterwards A at addr 5 reads 4 and oob_err=0.
- Reset mid-sweep: rst at cycle 100 of INIT -> full 367-cycle sweep restarts, with all outputs 0 during reset.

Source files
------------

// File: rtl/context_store_init_pkg.sv
// Shared defaults for the JPEG-LS context store: sizes,
// field widths, write-enable bit positions and FSM encoding.
package context_store_init_pkg;

    localparam int CS_DEPTH  = 367;
    localparam int CS_ADDR_W = 9;
    localparam int CS_A_W    = 16;
    localparam int CS_B_W    = 8;
    localparam int CS_C_W    = 8;
    localparam int CS_N_W    = 7;
    localparam int CS_NN_W   = 7;
    localparam int CS_A_INIT = 4;
    localparam int CS_N_INIT = 1;

    localparam int FLD_A  = 0;
    localparam int FLD_B  = 1;
    localparam int FLD_C  = 2;
    localparam int FLD_N  = 3;
    localparam int FLD_NN = 4;

    typedef enum logic {
        ST_IDLE_RDY = 1'b0,
        ST_INIT     = 1'b1
    } cs_state_t;

endpackage

// File: rtl/context_store_init_field_ram.sv
// One context field: 1R1W register array, registered read,
// write-first when reading the address being written.
module ctx_field_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 367,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;
    logic             w_hit;

    assign w_hit   = i_we && (i_waddr == i_raddr);
    assign o_rdata = r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= w_hit ? i_wdata : r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/context_store_init.sv
// JPEG-LS context store: five field RAMs, init sweep FSM,
// out-of-range detection and read-valid strobe.
module context_store_init
    import context_store_init_pkg::*;
#(
    parameter int DEPTH  = CS_DEPTH,
    parameter int ADDR_W = CS_ADDR_W,
    parameter int A_W    = CS_A_W,
    parameter int B_W    = CS_B_W,
    parameter int C_W    = CS_C_W,
    parameter int N_W    = CS_N_W,
    parameter int NN_W   = CS_NN_W,
    parameter int A_INIT = CS_A_INIT,
    parameter int N_INIT = CS_N_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_req,
    output logic              ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [A_W-1:0]    a_rd,
    output logic [B_W-1:0]    b_rd,
    output logic [C_W-1:0]    c_rd,
    output logic [N_W-1:0]    n_rd,
    output logic [NN_W-1:0]   nn_rd,
    input  logic [4:0]        wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [A_W-1:0]    a_wr,
    input  logic [B_W-1:0]    b_wr,
    input  logic [C_W-1:0]    c_wr,
    input  logic [N_W-1:0]    n_wr,
    input  logic [NN_W-1:0]   nn_wr,
    output logic              oob_err
);

    localparam logic [ADDR_W:0] LP_DEPTH =
        (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST =
        ADDR_W'(DEPTH-1);

    cs_state_t         r_state, w_state_nx;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nx;
    logic              r_rd_valid, r_rd_oob, r_oob;

    logic              w_init, w_rd_inb, w_wr_inb;
    logic              w_re;
    logic [4:0]        w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [A_W-1:0]    w_a_d, w_a_q;
    logic [B_W-1:0]    w_b_d, w_b_q;
    logic [C_W-1:0]    w_c_d, w_c_q;
    logic [N_W-1:0]    w_n_d, w_n_q;
    logic [NN_W-1:0]   w_nn_d, w_nn_q;

    assign w_init   = (r_state == ST_INIT);
    assign ready    = (r_state == ST_IDLE_RDY);
    assign w_rd_inb = {1'b0, rd_addr} < LP_DEPTH;
    assign w_wr_inb = {1'b0, wr_addr} < LP_DEPTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        unique case (r_state)
            ST_INIT: begin
                if (init_req) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == LP_LAST) begin
                    w_state_nx = ST_IDLE_RDY;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_IDLE_RDY: begin
                if (init_req) begin
                    w_state_nx = ST_INIT;
                    w_cnt_nx   = '0;
                end
            end
            default: w_state_nx = ST_INIT;
        endcase
    end

    // The sweep owns the write port; user traffic only when ready.
    assign w_we    = w_init ? 5'h1f
                   : (wr_en & {5{ready & w_wr_inb}});
    assign w_waddr = w_init ? r_cnt : wr_addr;
    assign w_re    = ready & rd_en & w_rd_inb;

    assign w_a_d  = w_init ? A_W'(A_INIT) : a_wr;
    assign w_b_d  = w_init ? '0 : b_wr;
    assign w_c_d  = w_init ? '0 : c_wr;
    assign w_n_d  = w_init ? N_W'(N_INIT) : n_wr;
    assign w_nn_d = w_init ? '0 : nn_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_oob   <= 1'b0;
        end else begin
            r_rd_valid <= ready & rd_en;
            if (ready & rd_en) begin
                r_rd_oob <= ~w_rd_inb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || init_req) begin
            r_oob <= 1'b0;
        end else if (ready &&
                     ((rd_en && !w_rd_inb) ||
                      ((|wr_en) && !w_wr_inb))) begin
            r_oob <= 1'b1;
        end
    end

    assign rd_valid = r_rd_valid;
    assign oob_err  = r_oob;
    assign a_rd     = r_rd_oob ? '0 : w_a_q;
    assign b_rd     = r_rd_oob ? '0 : w_b_q;
    assign c_rd     = r_rd_oob ? '0 : w_c_q;
    assign n_rd     = r_rd_oob ? '0 : w_n_q;
    assign nn_rd    = r_rd_oob ? '0 : w_nn_q;

    ctx_field_ram #(.WIDTH(A_W), .DEPTH(DEPTH), .AW(ADDR_W))
    u_a (
        .clk(clk), .rst(rst),
        .i_we(w_we[FLD_A]), .i_waddr(w_waddr),
        .i_wdata(w_a_d), .i_re(w_re),
        .i_raddr(rd_addr), .o_rdata(w_a_q)
    );

    ctx_field_ram #(.WIDTH(B_W), .DEPTH(DEPTH), .AW(ADDR_W))
    u_b (
        .clk(clk), .rst(rst),
        .i_we(w_we[FLD_B]), .i_waddr(w_waddr),
        .i_wdata(w_b_d), .i_re(w_re),
        .i_raddr(rd_addr), .o_rdata(w_b_q)
    );

    ctx_field_ram #(.WIDTH(C_W), .DEPTH(DEPTH), .AW(ADDR_W))
    u_c (
        .clk(clk), .rst(rst),
        .i_we(w_we[FLD_C]), .i_waddr(w_waddr),
        .i_wdata(w_c_d), .i_re(w_re),
        .i_raddr(rd_addr), .o_rdata(w_c_q)
    );

    ctx_field_ram #(.WIDTH(N_W), .DEPTH(DEPTH), .AW(ADDR_W))
    u_n (
        .clk(clk), .rst(rst),
        .i_we(w_we[FLD_N]), .i_waddr(w_waddr),
        .i_wdata(w_n_d), .i_re(w_re),
        .i_raddr(rd_addr), .o_rdata(w_n_q)
    );

    ctx_field_ram #(.WIDTH(NN_W), .DEPTH(DEPTH), .AW(ADDR_W))
    u_nn (
        .clk(clk), .rst(rst),
        .i_we(w_we[FLD_NN]), .i_waddr(w_waddr),
        .i_wdata(w_nn_d), .i_re(w_re),
        .i_raddr(rd_addr), .o_rdata(w_nn_q)
    );

endmodule

// File: tb/tb_context_store_init.sv
// Directed bench for context_store_init: vector table plus
// sweep, full-array, init_req and mid-sweep reset sequences.
module tb_context_store_init;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_req;
    logic        ready;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic        rd_valid;
    logic [15:0] a_rd;
    logic [7:0]  b_rd, c_rd;
    logic [6:0]  n_rd, nn_rd;
    logic [4:0]  wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] a_wr;
    logic [7:0]  b_wr, c_wr;
    logic [6:0]  n_wr, nn_wr;
    logic        oob_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    context_store_init dut (
        .clk(clk), .rst(rst), .init_req(init_req),
        .ready(ready), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .a_rd(a_rd), .b_rd(b_rd),
        .c_rd(c_rd), .n_rd(n_rd), .nn_rd(nn_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .a_wr(a_wr),
        .b_wr(b_wr), .c_wr(c_wr), .n_wr(n_wr),
        .nn_wr(nn_wr), .oob_err(oob_err)
    );

    typedef struct {
        logic [4:0]  we;
        logic [8:0]  wa;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [6:0]  n;
        logic [6:0]  nn;
        logic        re;
        logic [8:0]  ra;
        logic        ev;
        logic [15:0] ea;
        logic [7:0]  eb;
        logic [7:0]  ec;
        logic [6:0]  en;
        logic [6:0]  enn;
        logic        eo;
    } vec_t;

    vec_t v [15];

    logic [15:0] ma  [367];
    logic [7:0]  mb  [367];
    logic [7:0]  mc  [367];
    logic [6:0]  mn  [367];
    logic [6:0]  mnn [367];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    task automatic idle_in();
        init_req = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        a_wr     = '0;
        b_wr     = '0;
        c_wr     = '0;
        n_wr     = '0;
        nn_wr    = '0;
    endtask

    // Counts cycles until ready, keeping a read request
    // asserted to prove reads are ignored meanwhile.
    task automatic sweep(input string nm);
        int  cyc;
        bit  saw_v;
        cyc   = 0;
        saw_v = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 9'd5;
        while (!ready && cyc < 2000) begin
            tick();
            cyc++;
            if (rd_valid) saw_v = 1'b1;
        end
        rd_en = 1'b0;
        tick();
        if (rd_valid) saw_v = 1'b1;
        chk({nm, "_len"}, cyc, 367);
        chk({nm, "_novalid"}, 32'(saw_v), 0);
    endtask

    task automatic rd_chk(input string nm,
                          input logic [8:0] ad,
                          input logic [15:0] ea,
                          input logic [7:0] eb,
                          input logic [7:0] ec,
                          input logic [6:0] en,
                          input logic [6:0] enn);
        rd_en   = 1'b1;
        rd_addr = ad;
        tick();
        rd_en = 1'b0;
        chk({nm, "_v"},  32'(rd_valid), 1);
        chk({nm, "_a"},  32'(a_rd),  32'(ea));
        chk({nm, "_b"},  32'(b_rd),  32'(eb));
        chk({nm, "_c"},  32'(c_rd),  32'(ec));
        chk({nm, "_n"},  32'(n_rd),  32'(en));
        chk({nm, "_nn"}, 32'(nn_rd), 32'(enn));
    endtask

    initial begin
        // we wa a b c n nn | re ra | ev ea eb ec en enn eo
        v[0]  = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd0,   1, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 0};
        v[1]  = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd200, 1, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 0};
        v[2]  = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd366, 1, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 0};
        v[3]  = '{5'h09, 9'd10, 16'd77, 8'hFD, 8'h33, 7'd5, 7'd3,
                  0, 9'd0,   0, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 0};
        v[4]  = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd10,  1, 16'd77, 8'h00, 8'h00, 7'd5, 7'd0, 0};
        v[5]  = '{5'h04, 9'd20, 16'd0, 8'h00, 8'h09, 7'd0, 7'd0,
                  0, 9'd0,   0, 16'd77, 8'h00, 8'h00, 7'd5, 7'd0, 0};
        v[6]  = '{5'h04, 9'd20, 16'd9, 8'h11, 8'hFE, 7'd9, 7'd9,
                  1, 9'd20,  1, 16'd4, 8'h00, 8'hFE, 7'd1, 7'd0, 0};
        v[7]  = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd20,  1, 16'd4, 8'h00, 8'hFE, 7'd1, 7'd0, 0};
        v[8]  = '{5'h1F, 9'd30, 16'h1234, 8'h7F, 8'h80, 7'h7F, 7'h55,
                  1, 9'd30,  1, 16'h1234, 8'h7F, 8'h80, 7'h7F, 7'h55, 0};
        v[9]  = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  0, 9'd0,   0, 16'h1234, 8'h7F, 8'h80, 7'h7F, 7'h55, 0};
        v[10] = '{5'h1F, 9'd400, 16'd999, 8'h12, 8'h34, 7'd9, 7'd9,
                  0, 9'd0,   0, 16'h1234, 8'h7F, 8'h80, 7'h7F, 7'h55, 1};
        v[11] = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd400, 1, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0, 1};
        v[12] = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd0,   1, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 1};
        v[13] = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd144, 1, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 1};
        v[14] = '{5'h00, 9'd0, 16'd0, 8'h00, 8'h00, 7'd0, 7'd0,
                  1, 9'd366, 1, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0, 1};

        for (int i = 0; i < 367; i++) begin
            ma[i] = 16'd4; mb[i] = 8'h00; mc[i] = 8'h00;
            mn[i] = 7'd1;  mnn[i] = 7'd0;
        end
        ma[10] = 16'd77; mn[10] = 7'd5;
        mc[20] = 8'hFE;
        ma[30] = 16'h1234; mb[30] = 8'h7F; mc[30] = 8'h80;
        mn[30] = 7'h7F; mnn[30] = 7'h55;

        idle_in();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(ready), 0);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_a", 32'(a_rd), 0);
        chk("rst_n", 32'(n_rd), 0);
        chk("rst_oob", 32'(oob_err), 0);

        rst = 1'b0;
        sweep("sweep0");

        for (int i = 0; i < 15; i++) begin
            wr_en   = v[i].we;
            wr_addr = v[i].wa;
            a_wr    = v[i].a;
            b_wr    = v[i].b;
            c_wr    = v[i].c;
            n_wr    = v[i].n;
            nn_wr   = v[i].nn;
            rd_en   = v[i].re;
            rd_addr = v[i].ra;
            tick();
            chk($sformatf("v%0d_valid", i),
                32'(rd_valid), 32'(v[i].ev));
            chk($sformatf("v%0d_a", i), 32'(a_rd), 32'(v[i].ea));
            chk($sformatf("v%0d_b", i), 32'(b_rd), 32'(v[i].eb));
            chk($sformatf("v%0d_c", i), 32'(c_rd), 32'(v[i].ec));
            chk($sformatf("v%0d_n", i), 32'(n_rd), 32'(v[i].en));
            chk($sformatf("v%0d_nn", i),
                32'(nn_rd), 32'(v[i].enn));
            chk($sformatf("v%0d_oob", i),
                32'(oob_err), 32'(v[i].eo));
        end
        idle_in();

        for (int i = 0; i < 367; i++) begin
            rd_chk($sformatf("all%0d", i), 9'(i),
                   ma[i], mb[i], mc[i], mn[i], mnn[i]);
        end

        wr_en   = 5'h01;
        wr_addr = 9'd5;
        a_wr    = 16'd100;
        tick();
        idle_in();
        rd_chk("wr5", 9'd5, 16'd100, 8'h00, 8'h00, 7'd1, 7'd0);
        chk("pre_init_oob", 32'(oob_err), 1);

        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("init_ready", 32'(ready), 0);
        chk("init_oob", 32'(oob_err), 0);
        sweep("sweep1");
        rd_chk("post5", 9'd5, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0);
        rd_chk("post10", 9'd10, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0);
        chk("post_oob", 32'(oob_err), 0);

        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (100) tick();
        chk("mid_ready", 32'(ready), 0);
        rst = 1'b1;
        tick();
        chk("mrst_ready", 32'(ready), 0);
        chk("mrst_valid", 32'(rd_valid), 0);
        chk("mrst_a", 32'(a_rd), 0);
        chk("mrst_n", 32'(n_rd), 0);
        chk("mrst_oob", 32'(oob_err), 0);
        rst = 1'b0;
        sweep("sweep2");
        rd_chk("fin30", 9'd30, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0);
        rd_chk("fin366", 9'd366, 16'd4, 8'h00, 8'h00, 7'd1, 7'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
